// File: rtl/store_buffer_pkg.sv
// Shared types and default constants for the posted-write store buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package store_buffer_pkg;

    localparam int          SB_DEPTH     = 4;
    localparam logic [31:0] SB_DONE_ADDR = 32'd45600;
    localparam logic [31:0] SB_DONE_DATA = 32'd7;

    // One buffered store: the address travels with its data.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } store_entry_t;

    // Occupancy counters need one extra bit so that "full" is representable.
    function automatic int sb_count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Core-side store strobe plus memory-side valid/ready drain port of the store buffer.
// Latency: n/a (wiring only).
// Backpressure: Stall toward the core, mem_ready from memory.
interface store_buffer_if
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH
);
    localparam int CW = sb_count_w(DEPTH);

    logic          MemWrite;
    logic [31:0]   ALUResult;
    logic [31:0]   WriteData;
    logic          Stall;
    logic          mem_valid;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_data;
    logic          mem_ready;
    logic [CW-1:0] Count;
    logic          Overflow;
    logic          Done;

    // Environment side: the core issuing stores and the memory accepting them.
    modport master (
        output MemWrite, ALUResult, WriteData, mem_ready,
        input  Stall, mem_valid, mem_addr, mem_data, Count, Overflow, Done
    );

    // Buffer side.
    modport slave (
        input  MemWrite, ALUResult, WriteData, mem_ready,
        output Stall, mem_valid, mem_addr, mem_data, Count, Overflow, Done
    );
endinterface

// File: rtl/store_fifo.sv
// Generic synchronous FIFO of store entries with extra-MSB wrap pointers.
// Latency: a pushed entry is visible at the head one cycle after the push edge (no bypass).
// Backpressure: push ignored when full, pop ignored when empty; full/empty are registered-state decodes.
module store_fifo
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_push,
    input  store_entry_t            i_push_dat,
    input  logic                    i_pop,
    output store_entry_t            o_head_dat,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    store_entry_t r_mem [DEPTH];

    logic w_push;
    logic w_pop;

    // Same index with opposite lap bit means the writer is a full lap ahead.
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_count = r_wr_ptr - r_rd_ptr;

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    assign o_head_dat = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer advance; reset empties the FIFO and discards any pending entries.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write; contents are don't-care until covered by the pointers.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer: captures core stores and drains them in order to memory; optional
// completion-store flag under `STORE_BUFFER_DONE_EN. Latency: 1 cycle store-to-mem_valid when empty.
// Backpressure: Stall (registered full) to the core; head held stable while mem_valid && !mem_ready.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int          DEPTH     = SB_DEPTH,
    parameter logic [31:0] DONE_ADDR = SB_DONE_ADDR,
    parameter logic [31:0] DONE_DATA = SB_DONE_DATA
) (
    input  logic            clk,
    input  logic            reset,
    store_buffer_if.slave   sb
);
    localparam int CW = sb_count_w(DEPTH);

    store_entry_t  w_push_entry;
    store_entry_t  w_head;
    logic          w_full;
    logic          w_empty;
    logic          w_push_acc;
    logic [CW-1:0] w_count;
    logic          r_overflow;

    assign w_push_entry = '{addr: sb.ALUResult, data: sb.WriteData};
    assign w_push_acc   = sb.MemWrite && !w_full;

    store_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk      (clk),
        .i_rst_n    (reset),
        .i_push     (sb.MemWrite),
        .i_push_dat (w_push_entry),
        .i_pop      (sb.mem_ready),
        .o_head_dat (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (w_count)
    );

    assign sb.Stall     = w_full;
    assign sb.mem_valid = !w_empty;
    assign sb.mem_addr  = w_head.addr;
    assign sb.mem_data  = w_head.data;
    assign sb.Count     = w_count;
    assign sb.Overflow  = r_overflow;

    // Sticky overflow: a store presented while full is dropped, even if a pop frees a slot that cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (sb.MemWrite && w_full) begin
            r_overflow <= 1'b1;
        end
    end

`ifdef STORE_BUFFER_DONE_EN
    logic r_done;

    assign sb.Done = r_done;

    // Sticky completion flag, set when the magic store is actually accepted into the buffer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_done <= 1'b0;
        end else if (w_push_acc && (sb.ALUResult == DONE_ADDR) && (sb.WriteData == DONE_DATA)) begin
            r_done <= 1'b1;
        end
    end
`else
    logic w_unused_push_acc;

    // Completion detection compiled out entirely.
    assign sb.Done           = 1'b0;
    assign w_unused_push_acc = w_push_acc;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Randomized + directed bench for store_buffer against a queue-based reference model.
// Latency: model expects a pushed store at the head one cycle after the push edge.
// Backpressure: mem_ready driven by stimulus; Stall observed and compared.
module tb_store_buffer;
    import store_buffer_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] DADDR = 32'd45600;
    localparam logic [31:0] DDATA = 32'd7;

    logic clk;
    logic reset;

    store_buffer_if #(.DEPTH(DEPTH)) sb ();

    store_buffer #(
        .DEPTH     (DEPTH),
        .DONE_ADDR (DADDR),
        .DONE_DATA (DDATA)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: ordered list of pending stores plus the two sticky flags.
    store_entry_t m_q[$];
    logic         m_ovf;
    logic         m_done;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovf  = 1'b0;
        m_done = 1'b0;
    endtask

    // Applies the buffer's rules to the inputs seen at the rising edge.
    task automatic model_step();
        bit           full_now;
        bit           empty_now;
        store_entry_t e;
        full_now  = (m_q.size() == DEPTH);
        empty_now = (m_q.size() == 0);
        e.addr = sb.ALUResult;
        e.data = sb.WriteData;
        if (sb.MemWrite && full_now) m_ovf = 1'b1;
        if (!empty_now && sb.mem_ready) void'(m_q.pop_front());
        if (sb.MemWrite && !full_now) begin
            m_q.push_back(e);
`ifdef STORE_BUFFER_DONE_EN
            if (e.addr == DADDR && e.data == DDATA) m_done = 1'b1;
`endif
        end
    endtask

    task automatic check_all(input string tag);
        check_val({tag, ".valid"}, 32'(sb.mem_valid), 32'(m_q.size() != 0));
        check_val({tag, ".count"}, 32'(sb.Count),     32'(m_q.size()));
        check_val({tag, ".stall"}, 32'(sb.Stall),     32'(m_q.size() == DEPTH));
        check_val({tag, ".ovf"},   32'(sb.Overflow),  32'(m_ovf));
        check_val({tag, ".done"},  32'(sb.Done),      32'(m_done));
        if (m_q.size() != 0) begin
            check_val({tag, ".addr"}, sb.mem_addr, m_q[0].addr);
            check_val({tag, ".data"}, sb.mem_data, m_q[0].data);
        end
    endtask

    // Drive one cycle of inputs, advance past the edge, then compare.
    task automatic drive(input string tag, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic rdy);
        sb.MemWrite  = we;
        sb.ALUResult = a;
        sb.WriteData = d;
        sb.mem_ready = rdy;
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [31:0] hold_a;
        logic [31:0] hold_d;
        logic [31:0] ra;
        logic [31:0] rd;

        reset        = 1'b0;
        sb.MemWrite  = 1'b0;
        sb.ALUResult = '0;
        sb.WriteData = '0;
        sb.mem_ready = 1'b0;
        model_reset();
        #3;
        check_all("rst");
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Single store, immediately drained.
        drive("one_push", 1'b1, 32'h10, 32'hAA, 1'b1);
        check_val("one_lat_valid", 32'(sb.mem_valid), 32'd1);
        drive("one_pop", 1'b0, 32'h0, 32'h0, 1'b1);
        check_val("one_count0", 32'(sb.Count), 32'd0);

        // Fill past capacity with memory stalled, then drain in order.
        for (int i = 0; i < DEPTH + 1; i++)
            drive("fill", 1'b1, 32'(i), 32'(32'h100 + i), 1'b0);
        check_val("fill_stall", 32'(sb.Stall), 32'd1);
        check_val("fill_ovf",   32'(sb.Overflow), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            check_val("drain_order", sb.mem_addr, 32'(i));
            drive("drain", 1'b0, 32'h0, 32'h0, 1'b1);
        end
        check_val("drain_empty", 32'(sb.mem_valid), 32'd0);

        // Two entries, then simultaneous push/pop long enough to wrap the pointers.
        drive("pp_fill", 1'b1, 32'h200, 32'h300, 1'b0);
        drive("pp_fill", 1'b1, 32'h201, 32'h301, 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive("pp", 1'b1, 32'(32'h202 + i), 32'(32'h302 + i), 1'b1);
            check_val("pp_count2", 32'(sb.Count), 32'd2);
        end

        // Memory stalled for five cycles: head must not move.
        hold_a = sb.mem_addr;
        hold_d = sb.mem_data;
        for (int i = 0; i < 5; i++) begin
            drive("hold", 1'b0, 32'h0, 32'h0, 1'b0);
            check_val("hold_addr", sb.mem_addr, hold_a);
            check_val("hold_data", sb.mem_data, hold_d);
        end
        drive("hold_rel", 1'b0, 32'h0, 32'h0, 1'b1);
        drive("hold_rel", 1'b0, 32'h0, 32'h0, 1'b1);

        // Near-miss completion store, then the real one.
        drive("done_miss", 1'b1, DADDR, 32'd8, 1'b1);
        check_val("done_miss_flag", 32'(sb.Done), 32'd0);
        drive("done_hit", 1'b1, DADDR, DDATA, 1'b1);
        for (int i = 0; i < 3; i++)
            drive("done_sticky", 1'b0, 32'h0, 32'h0, 1'b1);

        // Reset mid-drain with three entries pending.
        for (int i = 0; i < 3; i++)
            drive("pre_rst", 1'b1, 32'(32'h400 + i), 32'(i), 1'b0);
        drive("pre_rst_ovf", 1'b0, 32'h0, 32'h0, 1'b0);
        sb.mem_ready = 1'b1;
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("rst_hold");
        reset = 1'b1;

        // Randomized traffic, occasionally hitting the completion pattern and ignoring Stall.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                ra = DADDR;
                rd = ($urandom_range(0, 1) == 0) ? DDATA : 32'd8;
            end else begin
                ra = $urandom;
                rd = $urandom;
            end
            drive("rand", ($urandom_range(0, 3) != 0), ra, rd, ($urandom_range(0, 2) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the processor core (`TOP`) and the data-memory port. It captures every store the core issues (`MemWrite`, address on `ALUResult`, data on `WriteData`) into a small FIFO and drains it to memory over a valid/ready handshake. It raises `Stall` toward the core when the FIFO is full. It can optionally flag the program-completion store in hardware.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `DONE_ADDR`, 32'd45600: completion-store address.
- `DONE_DATA`, 32'd7: completion-store data.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `MemWrite`  in  1  store strobe from the core; one store per cycle when high.
- `ALUResult`  in  32  store address.
- `WriteData`  in  32  store data.
- `Stall`  out  1  buffer full; the core must hold the current store.
- `mem_valid`  out  1  head entry is presented to memory.
- `mem_addr`  out  32  head entry address.
- `mem_data`  out  32  head entry data.
- `mem_ready`  in  1  memory accepts the head entry this cycle.
- `Count`  out  $clog2(DEPTH)+1  number of occupied entries.
- `Overflow`  out  1  sticky: a store arrived while the buffer was full.
- `Done`  out  1  sticky: the completion store was accepted.

## Operation
- Push: `MemWrite && !full` writes {`ALUResult`, `WriteData`} at the write pointer.
- Pop: `mem_valid && mem_ready` advances the read pointer.
- Pointers are $clog2(DEPTH)+1 bits wide, wrap modulo 2·DEPTH, and index storage with their low bits.
  - full = pointers differ only in the MSB.
  - empty = pointers equal.
- `Count` = wr_ptr − rd_ptr (modulo arithmetic).
- `Stall` = full, decoded from registered state only; it has no combinational path from `MemWrite` or `mem_ready`.
- Full with `MemWrite` high: the store is rejected and `Overflow` sets, even if a pop occurs in the same cycle. The core is expected to have honoured `Stall`.
- Empty with `MemWrite` high: push only. There is no bypass, so the entry is not visible to memory in the same cycle.
- Simultaneous push and pop when neither full nor empty: both take effect and `Count` is unchanged.
- `mem_valid` = !empty. `mem_addr`/`mem_data` are the head entry and stay stable while `mem_valid && !mem_ready`.
- Stores drain strictly in issue order. There is no merging and no reordering.
- `Overflow` clears only on reset.

## Timing
- Store accepted at edge N appears on `mem_valid` after edge N (empty-buffer latency 1 cycle).
- Throughput: one push and one pop per cycle.
- Reset assertion (async):
  - all pointers go to 0, so `mem_valid`=0 and `Count`=0 immediately;
  - `Stall`, `Overflow` and `Done` go to 0;
  - buffered entries are discarded, including mid-drain.
- Storage contents need no reset.
- After reset deasserts, the first push is at the next rising edge.

## Configuration
- `STORE_BUFFER_DONE_EN`, defined:
  - a push with address == `DONE_ADDR` and data == `DONE_DATA` sets `Done` at that edge;
  - `Done` stays high until reset.
- `STORE_BUFFER_DONE_EN`, undefined:
  - `Done` is tied to 0;
  - no comparators are synthesised.

## Structure
- Package `store_buffer_pkg`:
  - `store_entry_t` packed struct {addr[31:0], data[31:0]};
  - default constants `SB_DEPTH`, `SB_DONE_ADDR`, `SB_DONE_DATA`.
- Sub-module `store_fifo` (generic synchronous FIFO of `store_entry_t` with push/pop/full/empty/count).
- `store_buffer` wraps `store_fifo` and adds the handshake mapping, the `Overflow` flag and the `Done` flag.

## Test plan
- Reset, then one store (addr 0x10, data 0xAA) with `mem_ready`=1 -> `mem_valid` high exactly one cycle later with 0x10/0xAA, then `Count` returns to 0.
- `mem_ready`=0, DEPTH+1 consecutive stores -> `Stall` rises after the 4th, `Count`=4, 5th store sets `Overflow`. Then raise `mem_ready` -> entries drain in order 0..3.
- Buffer at 2 entries, push and pop in the same cycle -> `Count` stays 2 and order is preserved; repeat over 10 cycles to exercise pointer wrap.
- Hold `mem_ready`=0 for 5 cycles with an entry pending -> `mem_addr`/`mem_data` stable throughout.
- Macro defined: store addr 45600, data 7 -> `Done`=1 next cycle and sticky. Store addr 45600, data 8 -> `Done` stays 0. Macro undefined -> `Done` always 0.
- Assert `reset` mid-drain with 3 entries -> `mem_valid`, `Count`, `Stall`, `Overflow` and `Done` go to 0 asynchronously, before the next clock edge.
